pll_lock_timebase: RTL
======================

# pll_lock_timebase

Consumer-side companion to the 1.048576 MHz clock PLL. It takes the PLL output clock and the asynchronous `locked` flag, qualifies lock with a synchroniser and a stability window, and only then releases a synchronous system reset. While lock holds, a free-running binary divider generates the 1 Hz and 64 Hz tick strobes that drive the clock/time-keeping logic. Lock loss is detected, counted and turns back into a system reset.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before release; legal range 1..65535.
- `DIV_WIDTH`, default 20: divider width; the 1 Hz tick period is 2^DIV_WIDTH cycles (2^20 = 1.048576 MHz).
- `SUB_WIDTH`, default 14: sub-tick divider width; must be less than `DIV_WIDTH`; period 2^SUB_WIDTH cycles (64 Hz).

Ports:
- `refclk`  in  1  PLL output clock (`outclk_0`); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock flag; asynchronous to `refclk`.
- `sys_rst_n`  out  1  registered system reset, active low; high only in RUN.
- `tick_1hz`  out  1  one-cycle strobe every 2^DIV_WIDTH cycles in RUN.
- `tick_sub`  out  1  one-cycle strobe every 2^SUB_WIDTH cycles in RUN.
- `lock_loss_cnt`  out  4  saturating count of RUN-to-WAIT lock losses.
- `timebase_ok`  out  1  registered; equal to `sys_rst_n`; status/LED use.

## Operation
- Synchroniser: two flops `locked` -> `sync1` -> `lock_s`, both cleared by `rst_n`.
- FSM states: WAIT, STABLE, RUN.
  - WAIT: if `lock_s`=1, go to STABLE with `stab_cnt`=0.
  - STABLE: if `lock_s`=0, go to WAIT. Else if `stab_cnt`=STABLE_CYCLES-1, go to RUN. Else increment `stab_cnt`.
  - RUN: if `lock_s`=0, go to WAIT and increment `lock_loss_cnt`, saturating at 15.
- Only the RUN-to-WAIT transition counts as a loss. Dropouts in STABLE are not counted.
- `sys_rst_n` and `timebase_ok` are registered from the next state being RUN, so they change on the same edge as the state.
- Divider `div` (DIV_WIDTH bits):
  - Held at 0 outside RUN. Increments by 1 per cycle in RUN and wraps from all-ones to 0.
  - `tick_1hz` is registered high for one cycle on the edge where `div` wraps (all-ones -> 0).
  - `tick_sub` is registered high for one cycle on the edge where `div[SUB_WIDTH-1:0]` wraps.
  - Both ticks fire in the same cycle at every 1 Hz boundary.
- Leaving RUN clears `div`, and both ticks are 0 from that edge onward. There is no partial-second carry-over.
- Async reset (`rst_n`=0): state WAIT; `stab_cnt`, `div`, sync flops and `lock_loss_cnt` = 0; all outputs 0. Takes effect immediately, mid-RUN included. Release follows the normal bring-up path.

## Timing
- Bring-up: `locked` rises before edge 1. `sync1`=1 at edge 1, `lock_s`=1 at edge 2, STABLE at edge 3, RUN and `sys_rst_n`=1 at edge 3+STABLE_CYCLES. Default: edge 1027.
- First tick: `div`=0 at the RUN entry edge E. First `tick_sub` at E+2^SUB_WIDTH. First `tick_1hz` at E+2^DIV_WIDTH. Period is exact thereafter.
- Loss: `locked` falls before edge k. `sys_rst_n`=0, state WAIT and `lock_loss_cnt`+1 at edge k+2.
- Lock pulses shorter than one `refclk` period may be missed. This is acceptable.
- Simultaneous loss on a tick edge: the state change wins and the tick is not emitted.

## Test plan
- Reset: hold `rst_n`=0 with `locked`=1 -> all outputs 0. Assert `rst_n`=0 mid-RUN -> `sys_rst_n`, `timebase_ok`, ticks and `lock_loss_cnt` go 0 asynchronously, before the next edge.
- Bring-up with STABLE_CYCLES=16: `locked` rises before edge 1 -> `sys_rst_n`=1 exactly at edge 19, not at 18.
- Glitch in STABLE (STABLE_CYCLES=16): `locked`=0 for 3 cycles when `stab_cnt`=10 -> return to WAIT, `lock_loss_cnt` stays 0, full 16-cycle window restarts after relock.
- Divider with DIV_WIDTH=6, SUB_WIDTH=3: `tick_sub` every 8 cycles, `tick_1hz` every 64 cycles and coincident with every 8th `tick_sub`. First `tick_1hz` arrives 64 cycles after RUN entry.
- Lock loss in RUN: drop `locked` before edge k -> `sys_rst_n`=0 at edge k+2, `lock_loss_cnt`=1, ticks stop, and the first tick after relock is a full period after the new RUN entry.
- Saturation: 17 RUN losses -> `lock_loss_cnt`=15, with no wrap to 0.

Source files
------------

// File: rtl/pll_lock_timebase.sv
// Lock qualification and 1 Hz / sub-tick timebase for the 1.048576 MHz PLL clock.
// Releases a registered system reset only after a stable synchronised lock window.
module pll_lock_timebase #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned DIV_WIDTH     = 20,
  parameter int unsigned SUB_WIDTH     = 14
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       sys_rst_n,
  output logic       tick_1hz,
  output logic       tick_sub,
  output logic [3:0] lock_loss_cnt,
  output logic       timebase_ok
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_STABLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [CNT_W-1:0]     STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MAX   = '1;
  localparam logic [SUB_WIDTH-1:0] SUB_MAX   = '1;

  logic                 sync1;
  logic                 lock_s;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     stab_q, stab_d;
  logic [3:0]           loss_q, loss_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 t1_d, ts_d;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked;
      lock_s <= sync1;
    end
  end

  // Next-state, stability window, loss counter and divider
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    loss_d  = loss_q;
    div_d   = '0;
    t1_d    = 1'b0;
    ts_d    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          stab_d  = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stab_d = stab_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          if (loss_q != 4'hf) begin
            loss_d = loss_q + 4'd1;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
    // A state change on a tick edge suppresses the tick and clears the divider
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      div_d = div_q + DIV_WIDTH'(1);
      t1_d  = (div_q == DIV_MAX);
      ts_d  = (div_q[SUB_WIDTH-1:0] == SUB_MAX);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      stab_q      <= '0;
      loss_q      <= '0;
      div_q       <= '0;
      tick_1hz    <= 1'b0;
      tick_sub    <= 1'b0;
      sys_rst_n   <= 1'b0;
      timebase_ok <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      loss_q      <= loss_d;
      div_q       <= div_d;
      tick_1hz    <= t1_d;
      tick_sub    <= ts_d;
      sys_rst_n   <= (state_d == ST_RUN);
      timebase_ok <= (state_d == ST_RUN);
    end
  end

  assign lock_loss_cnt = loss_q;

endmodule
